// File: rtl/rxtx_pkg.sv
// Shared constants for the TX job executor: job word layout, FSM encodings
// and skid buffer sizing.
package rxtx_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 8;
  localparam int DATA_W_DEF = 64;

  // Job word layout: {base address, length}, length in the low bits.
  localparam int JOB_LEN_LSB  = 0;
  localparam int JOB_ADDR_LSB = JOB_LEN_LSB + LEN_W_DEF;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry fall-through buffer between the memory return path and the stream
// port; an empty buffer forwards its input straight to the output.
module stream_skid_buffer
  import rxtx_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [W-1:0]     in_data_i,
  output logic             out_valid_o,
  output logic [W-1:0]     out_data_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     r_mem [SKID_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty  = (r_count == '0);
  assign w_bypass = w_empty && in_valid_i && out_ready_i;
  assign w_push   = in_valid_i && !w_bypass && (r_count != CNT_W'(SKID_DEPTH));
  assign w_pop    = !w_empty && out_ready_i;

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data_i;
  end

  assign out_valid_o = !w_empty || in_valid_i;
  assign out_data_o  = !w_empty  ? r_mem[r_rd_ptr] :
                       in_valid_i ? in_data_i : '0;
  assign count_o     = r_count;

endmodule

// File: rtl/tx_job_executor.sv
// Pops {base, len} jobs from the arbiter, reads len words from packet memory
// and streams them out with a last tag. Optional stats: `TX_JOB_EXEC_STATS_EN.
module tx_job_executor
  import rxtx_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int LEN_W  = LEN_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int JOB_W  = ADDR_W + LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [JOB_W-1:0]  job_data_i,
  input  logic              job_valid_i,
  output logic              job_pop_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o
`ifdef TX_JOB_EXEC_STATS_EN
  ,
  output logic [31:0]       stat_jobs_o,
  output logic [31:0]       stat_words_o
`endif
);

  localparam int ADDR_LSB = JOB_LEN_LSB + LEN_W;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_rd_pend;
  logic              r_rd_last;

  logic [ADDR_W-1:0] w_job_addr;
  logic [LEN_W-1:0]  w_job_len;
  logic [CNT_W-1:0]  w_occ;
  logic              w_credit;
  logic              w_issue;
  logic              w_accept;
  logic              w_out_valid;
  logic [DATA_W:0]   w_out_word;

  assign w_job_len  = job_data_i[JOB_LEN_LSB +: LEN_W];
  assign w_job_addr = job_data_i[ADDR_LSB +: ADDR_W];

  // One read may be in flight while one word sits buffered; never exceed two.
  assign w_credit = (w_occ == '0) || ((w_occ == CNT_W'(1)) && !r_rd_pend);
  assign w_accept = w_out_valid && m_ready_i;

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    w_state_nxt = r_state;
    job_pop_o   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (job_valid_i && !rst_i) begin
          job_pop_o = 1'b1;
          if (w_job_len != '0) w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_rem == LEN_W'(1)) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_accept && w_out_word[DATA_W]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_issue;
      r_rd_last <= w_issue && (r_rem == LEN_W'(1));
      if (job_pop_o) begin
        r_addr <= w_job_addr;
        r_rem  <= w_job_len;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - LEN_W'(1);
      end
    end
  end

  stream_skid_buffer #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (r_rd_pend),
    .in_data_i   ({r_rd_last, mem_rd_data_i}),
    .out_valid_o (w_out_valid),
    .out_data_o  (w_out_word),
    .out_ready_i (m_ready_i),
    .count_o     (w_occ)
  );

  assign mem_rd_en_o   = w_issue;
  assign mem_rd_addr_o = (r_state == ST_IDLE) ? '0 : r_addr;
  assign m_valid_o     = w_out_valid;
  assign m_data_o      = w_out_word[DATA_W-1:0];
  assign m_last_o      = w_out_word[DATA_W];
  assign busy_o        = (r_state != ST_IDLE) || (w_occ != '0) || r_rd_pend;

`ifdef TX_JOB_EXEC_STATS_EN
  logic [31:0] r_stat_jobs;
  logic [31:0] r_stat_words;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_jobs  <= '0;
      r_stat_words <= '0;
    end else begin
      if (job_pop_o) r_stat_jobs  <= r_stat_jobs + 32'd1;
      if (w_accept)  r_stat_words <= r_stat_words + 32'd1;
    end
  end

  assign stat_jobs_o  = r_stat_jobs;
  assign stat_words_o = r_stat_words;
`endif

endmodule

// File: tb/tb_tx_job_executor.sv
// Self-checking bench for tx_job_executor: job table plus hand-written
// back-to-back and mid-job reset sequences, scoreboarded stream and reads.
module tb_tx_job_executor;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] GARBAGE = 64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    bit                rnd;
    int                exp_idle;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic [ADDR_W+LEN_W-1:0]   job_data_i;
  logic                      job_valid_i;
  logic                      job_pop_o;
  logic                      mem_rd_en_o;
  logic [ADDR_W-1:0]         mem_rd_addr_o;
  logic [DATA_W-1:0]         mem_rd_data_i;
  logic [DATA_W-1:0]         m_data_o;
  logic                      m_valid_o;
  logic                      m_last_o;
  logic                      m_ready_i;
  logic                      busy_o;
`ifdef TX_JOB_EXEC_STATS_EN
  logic [31:0]               stat_jobs_o;
  logic [31:0]               stat_words_o;
`endif

  always #5 clk = ~clk;

  tx_job_executor dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .job_data_i    (job_data_i),
    .job_valid_i   (job_valid_i),
    .job_pop_o     (job_pop_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_last_o      (m_last_o),
    .m_ready_i     (m_ready_i),
    .busy_o        (busy_o)
`ifdef TX_JOB_EXEC_STATS_EN
    ,
    .stat_jobs_o   (stat_jobs_o),
    .stat_words_o  (stat_words_o)
`endif
  );

  int              n_cmp = 0;
  int              n_bad = 0;
  int              cyc   = 0;
  bit              ready_rand = 1'b0;
  logic [ADDR_W-1:0] exp_addr [$];
  logic [DATA_W:0]   exp_q    [$];
  int              issued   = 0;
  int              accepted = 0;
  bit              prev_stall = 1'b0;
  logic [DATA_W:0] prev_word;
  vec_t            vecs [7];

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {22'h2A5A5A, a, 22'h15F0F0, ~a};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Packet memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk)
    mem_rd_data_i <= mem_rd_en_o ? mem_word(mem_rd_addr_o) : GARBAGE;

  always @(posedge clk) begin
    #1;
    m_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard monitor: reads and stream words against queued expectations.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_addr.delete();
      exp_q.delete();
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      check("occupancy_le_2", 96'((issued - accepted) <= 2), 96'(1));
      if (prev_stall) begin
        check("hold_valid", 96'(m_valid_o), 96'(1));
        check("hold_word", 96'({m_last_o, m_data_o}), 96'(prev_word));
      end
      if (mem_rd_en_o) begin
        check("rd_expected", 96'(exp_addr.size() != 0), 96'(1));
        if (exp_addr.size() != 0)
          check("rd_addr", 96'(mem_rd_addr_o), 96'(exp_addr.pop_front()));
        issued++;
      end
      if (m_valid_o && m_ready_i) begin
        check("word_expected", 96'(exp_q.size() != 0), 96'(1));
        if (exp_q.size() != 0)
          check("word", 96'({m_last_o, m_data_o}), 96'(exp_q.pop_front()));
        accepted++;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_word  = {m_last_o, m_data_o};
    end
  end

  task automatic drive_job(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    @(posedge clk);
    #1;
    job_data_i  = {addr, len};
    job_valid_i = 1'b1;
  endtask

  // Waits for the pop of the currently driven job, then queues its words.
  task automatic await_pop(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                           output int pop_cyc);
    bit seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      seen = job_pop_o;
    end
    check("pop_seen", 96'(seen), 96'(1));
    check("busy_at_pop", 96'(busy_o), 96'(0));
    check("no_overlap", 96'(exp_q.size()), 96'(0));
    pop_cyc = cyc;
    for (int i = 0; i < int'(len); i++) begin
      logic [ADDR_W-1:0] a;
      a = addr + ADDR_W'(i);
      exp_addr.push_back(a);
      exp_q.push_back({(i == int'(len) - 1), mem_word(a)});
    end
  endtask

  task automatic wait_idle(input int len, input int exp_idle);
    int  k    = 0;
    bit  done = 1'b0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
      if (exp_idle > 0 && len > 0) begin
        if (k == 1) begin
          check("first_rd_en", 96'(mem_rd_en_o), 96'(1));
          check("no_early_valid", 96'(m_valid_o), 96'(0));
        end
        if (k == 2) check("first_valid", 96'(m_valid_o), 96'(1));
      end
      if (!busy_o) done = 1'b1;
    end
    check("idle_reached", 96'(done), 96'(1));
    if (exp_idle > 0) check("job_cycles", 96'(k), 96'(exp_idle));
    check("queue_drained", 96'(exp_q.size()), 96'(0));
  endtask

  task automatic run_job(input vec_t v);
    int t;
    ready_rand = v.rnd;
    drive_job(v.addr, v.len);
    await_pop(v.addr, v.len, t);
    @(posedge clk);
    #1;
    job_valid_i = 1'b0;
    wait_idle(int'(v.len), v.exp_idle);
    ready_rand = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_a;
    int t_b;
    rst_i       = 1'b1;
    job_valid_i = 1'b0;
    job_data_i  = '0;

    // {addr, len, random ready, cycles from pop until busy low (-1: not timed)}
    vecs[0] = '{10'h010, 8'd4,   1'b0, 6};
    vecs[1] = '{10'h100, 8'd0,   1'b0, 1};
    vecs[2] = '{10'h3FE, 8'd4,   1'b0, 6};
    vecs[3] = '{10'h055, 8'd8,   1'b1, -1};
    vecs[4] = '{10'h200, 8'd1,   1'b0, 3};
    vecs[5] = '{10'h3FF, 8'd3,   1'b1, -1};
    vecs[6] = '{10'h0F0, 8'd255, 1'b0, 257};

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_pop", 96'(job_pop_o), 96'(0));
    check("rst_rd_en", 96'(mem_rd_en_o), 96'(0));
    check("rst_rd_addr", 96'(mem_rd_addr_o), 96'(0));
    check("rst_m_valid", 96'(m_valid_o), 96'(0));
    check("rst_m_last", 96'(m_last_o), 96'(0));
    check("rst_m_data", 96'(m_data_o), 96'(0));
    check("rst_busy", 96'(busy_o), 96'(0));

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Back-to-back: second job held valid must pop right after the first drains.
    drive_job(10'h020, 8'd5);
    await_pop(10'h020, 8'd5, t_a);
    @(posedge clk);
    #1;
    job_data_i = {10'h080, 8'd3};
    await_pop(10'h080, 8'd3, t_b);
    check("b2b_pop_gap", 96'(t_b - t_a), 96'(7));
    @(posedge clk);
    #1;
    job_valid_i = 1'b0;
    wait_idle(3, 5);

    // Reset in the middle of a read phase, then a fresh job.
    drive_job(10'h123, 8'd6);
    await_pop(10'h123, 8'd6, t_a);
    @(posedge clk);
    #1;
    job_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_pop", 96'(job_pop_o), 96'(0));
    check("mid_rst_rd_en", 96'(mem_rd_en_o), 96'(0));
    check("mid_rst_rd_addr", 96'(mem_rd_addr_o), 96'(0));
    check("mid_rst_m_valid", 96'(m_valid_o), 96'(0));
    check("mid_rst_m_last", 96'(m_last_o), 96'(0));
    check("mid_rst_m_data", 96'(m_data_o), 96'(0));
    check("mid_rst_busy", 96'(busy_o), 96'(0));
    run_job('{10'h050, 8'd5, 1'b0, 7});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
